fpalu_result_sink: RTL and testbench

Receiving end of the fpalu result stream. It accepts each 32-bit single-precision result plus its overflow flag over a valid/ready handshake, and decodes the result into sign, exponent, fraction and IEEE-754 class. Decoded entries are buffered in a small first-word-fall-through FIFO and presented downstream with valid/ready. It keeps saturating per-class and overflow statistics for bench and debug readout.

---
 rtl/fpalu_result_sink.sv | 126 ++++++++++++
 tb/tb_fpalu_result_sink.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_result_sink.sv
// Receiving end of the fpalu result stream: classifies each accepted IEEE-754 single
// result, buffers it in a first-word-fall-through FIFO and keeps saturating statistics.
module fpalu_result_sink #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                s_in,
    input  logic                       ovf_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sign,
    output logic [7:0]                 out_exp,
    output logic [22:0]                out_frac,
    output logic [2:0]                 out_class,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic [CNT_W-1:0]           inf_cnt,
    output logic [CNT_W-1:0]           nan_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_DENORM = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    // Distributed storage: the head must be readable in the same cycle out_valid rises.
    logic [31:0] word_mem  [DEPTH];
    logic [2:0]  class_mem [DEPTH];
    logic        ovf_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic [2:0]    cls_in;
    logic          push;
    logic          pop;
    logic [2:0]    cnt_inc;

    assign in_ready  = (count_reg != FULL_LEVEL);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        cls_in = CLS_NORMAL;
        if (s_in[30:23] == 8'h00) begin
            cls_in = (s_in[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
        end else if (s_in[30:23] == 8'hFF) begin
            if (s_in[22:0] == 23'd0)
                cls_in = CLS_INF;
            else if (s_in[22])
                cls_in = CLS_QNAN;
            else
                cls_in = CLS_SNAN;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            word_mem[wr_ptr_reg]  <= s_in;
            class_mem[wr_ptr_reg] <= cls_in;
            ovf_mem[wr_ptr_reg]   <= ovf_in;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign out_sign   = word_mem[rd_ptr_reg][31];
    assign out_exp    = word_mem[rd_ptr_reg][30:23];
    assign out_frac   = word_mem[rd_ptr_reg][22:0];
    assign out_class  = class_mem[rd_ptr_reg];
    assign out_ovf    = ovf_mem[rd_ptr_reg];
    assign fifo_count = count_reg;

    assign cnt_inc = {push & ((cls_in == CLS_QNAN) | (cls_in == CLS_SNAN)),
                      push & (cls_in == CLS_INF),
                      push & ovf_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else if (cnt_inc[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    endgenerate

    assign ovf_cnt = g_cnt[0].cnt_reg;
    assign inf_cnt = g_cnt[1].cnt_reg;
    assign nan_cnt = g_cnt[2].cnt_reg;
endmodule

// File: tb/tb_fpalu_result_sink.sv
// Table-driven, scoreboard-checked bench for fpalu_result_sink; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_fpalu_result_sink;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] s;
        logic        ovf;
        logic [2:0]  cls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] s_in = 32'd0;
    logic        ovf_in = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_sign, out_ovf;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic [2:0]  out_class;
    logic [2:0]  fifo_count;
    logic [15:0] ovf_cnt, inf_cnt, nan_cnt;

    logic        d2_in_ready, d2_out_valid, d2_out_sign, d2_out_ovf;
    logic [7:0]  d2_out_exp;
    logic [22:0] d2_out_frac;
    logic [2:0]  d2_out_class;
    logic [2:0]  d2_fifo_count;
    logic [1:0]  d2_ovf_cnt, d2_inf_cnt, d2_nan_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ovf, n_inf, n_nan;
    vec_t vecs[9];
    vec_t q[$];

    always #5 clk = ~clk;

    fpalu_result_sink #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s_in(s_in), .ovf_in(ovf_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_class(out_class), .out_ovf(out_ovf), .fifo_count(fifo_count),
        .ovf_cnt(ovf_cnt), .inf_cnt(inf_cnt), .nan_cnt(nan_cnt)
    );

    fpalu_result_sink #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
        .s_in(s_in), .ovf_in(ovf_in), .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_sign(d2_out_sign), .out_exp(d2_out_exp), .out_frac(d2_out_frac),
        .out_class(d2_out_class), .out_ovf(d2_out_ovf), .fifo_count(d2_fifo_count),
        .ovf_cnt(d2_ovf_cnt), .inf_cnt(d2_inf_cnt), .nan_cnt(d2_nan_cnt)
    );

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of handshake: outputs checked at negedge against the queue model.
    task automatic step(input logic iv, input vec_t v, input logic ordy, output logic accepted);
        vec_t e;
        logic do_pop;
        in_valid  = iv;
        s_in      = v.s;
        ovf_in    = v.ovf;
        out_ready = ordy;
        @(negedge clk);
        check("fifo_count", 32'(fifo_count), q.size());
        check("d2_fifo_count", 32'(d2_fifo_count), q.size());
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        check("d2_in_ready", 32'(d2_in_ready), 32'(q.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("d2_out_valid", 32'(d2_out_valid), 32'(q.size() != 0));
        check("ovf_cnt", 32'(ovf_cnt), sat(n_ovf, 65535));
        check("inf_cnt", 32'(inf_cnt), sat(n_inf, 65535));
        check("nan_cnt", 32'(nan_cnt), sat(n_nan, 65535));
        check("d2_ovf_cnt", 32'(d2_ovf_cnt), sat(n_ovf, 3));
        check("d2_inf_cnt", 32'(d2_inf_cnt), sat(n_inf, 3));
        check("d2_nan_cnt", 32'(d2_nan_cnt), sat(n_nan, 3));
        accepted = iv && (q.size() != DEPTH);
        do_pop   = ordy && (q.size() != 0);
        if (do_pop) begin
            e = q.pop_front();
            check("out_sign", 32'(out_sign), 32'(e.s[31]));
            check("out_exp", 32'(out_exp), 32'(e.s[30:23]));
            check("out_frac", 32'(out_frac), 32'(e.s[22:0]));
            check("out_class", 32'(out_class), 32'(e.cls));
            check("out_ovf", 32'(out_ovf), 32'(e.ovf));
            check("d2_out_word", {d2_out_sign, d2_out_exp, d2_out_frac}, e.s);
            check("d2_out_class", 32'(d2_out_class), 32'(e.cls));
            check("d2_out_ovf", 32'(d2_out_ovf), 32'(e.ovf));
            $display("pop  word=0x%08h class=%0d ovf=%0d", {out_sign, out_exp, out_frac},
                     out_class, out_ovf);
        end
        if (accepted) begin
            q.push_back(v);
            if (v.ovf) n_ovf++;
            if (v.cls == 3'd3) n_inf++;
            if (v.cls == 3'd4 || v.cls == 3'd5) n_nan++;
            $display("push word=0x%08h ovf=%0d", v.s, v.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic iv, input vec_t v);
        rst       = 1'b1;
        in_valid  = iv;
        s_in      = v.s;
        ovf_in    = v.ovf;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        n_ovf = 0;
        n_inf = 0;
        n_nan = 0;
        $display("reset in_valid=%0d", iv);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++)
            step(1'b0, vecs[0], 1'b1, acc);
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int   idx;
        vecs[0] = '{32'h0deeee00, 1'b0, 3'd2};
        vecs[1] = '{32'h7f800000, 1'b1, 3'd3};
        vecs[2] = '{32'h7fc00000, 1'b0, 3'd4};
        vecs[3] = '{32'h7f800001, 1'b0, 3'd5};
        vecs[4] = '{32'h80000000, 1'b0, 3'd0};
        vecs[5] = '{32'h00000001, 1'b0, 3'd1};
        vecs[6] = '{32'h7f7fffff, 1'b0, 3'd2};
        vecs[7] = '{32'hff800000, 1'b1, 3'd3};
        vecs[8] = '{32'hffc00001, 1'b1, 3'd4};

        do_reset(1'b0, vecs[0]);

        // Single normal result, then pop.
        step(1'b1, vecs[0], 1'b0, acc);
        check("t1_exp", 32'(out_exp), 32'h1B);
        check("t1_frac", 32'(out_frac), 32'h6EEE00);
        step(1'b0, vecs[0], 1'b1, acc);
        step(1'b0, vecs[0], 1'b0, acc);

        // Fill with special values, reject a fifth push, then drain in order.
        do_reset(1'b0, vecs[0]);
        for (int i = 1; i <= 4; i++)
            step(1'b1, vecs[i], 1'b0, acc);
        step(1'b1, vecs[5], 1'b0, acc);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        check("t2_ovf_cnt", 32'(ovf_cnt), 32'd1);
        check("t2_inf_cnt", 32'(inf_cnt), 32'd1);
        check("t2_nan_cnt", 32'(nan_cnt), 32'd2);
        drain();

        // Full FIFO with both sides active across pointer wrap.
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vecs[idx % 9], 1'b0, acc);
            if (acc) idx++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[idx % 9], 1'b1, acc);
            if (acc) idx++;
        end
        check("t3_level", 32'(fifo_count), 32'd3);
        drain();

        // Pass-through with consumer always ready.
        step(1'b1, vecs[5], 1'b1, acc);
        step(1'b1, vecs[6], 1'b1, acc);
        step(1'b0, vecs[0], 1'b1, acc);
        step(1'b0, vecs[0], 1'b1, acc);

        // Table sweep: every vector pushed and popped one cycle later.
        for (int i = 0; i < 9; i++)
            step(1'b1, vecs[i], 1'b1, acc);
        drain();

        // Reset with three entries stored and a push pending.
        for (int i = 0; i < 3; i++)
            step(1'b1, vecs[i + 1], 1'b0, acc);
        do_reset(1'b1, vecs[8]);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        step(1'b0, vecs[0], 1'b1, acc);

        // Saturation of the 2-bit overflow counter.
        for (int i = 0; i < 6; i++)
            step(1'b1, vecs[7], 1'b1, acc);
        step(1'b0, vecs[0], 1'b1, acc);
        check("t6_d2_ovf_cnt", 32'(d2_ovf_cnt), 32'd3);
        check("t6_ovf_cnt", 32'(ovf_cnt), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
